// File: rtl/fulladder_structural.sv
// Ripple-carry adder built from gate-level full-adder cells, with registered copies of the result.
// Optional macro FA_SELFCHECK_EN adds err_q, a sticky flag comparing the gate chain against a behavioural sum.

module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p_w;
    logic g_w;
    logic t_w;

    xor u_xor_p (p_w, a_i, b_i);
    xor u_xor_s (s_o, p_w, c_i);
    and u_and_g (g_w, a_i, b_i);
    and u_and_t (t_w, c_i, p_w);
    or  u_or_c  (c_o, g_w, t_w);
endmodule

module fulladder_structural #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q
`ifdef FA_SELFCHECK_EN
    ,
    output logic             err_q
`endif
);
    logic [WIDTH:0]   c_w;
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    assign c_w[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c_w[i]),
            .s_o (sum_w[i]),
            .c_o (c_w[i+1])
        );
    end

    assign sum  = sum_w;
    assign cout = c_w[WIDTH];
    // Carry into the MSB cell vs carry out of it; for WIDTH=1 this is cin ^ cout.
    assign ovf  = c_w[WIDTH-1] ^ c_w[WIDTH];

    always_comb begin
        sum_d  = sum;
        cout_d = cout;
        ovf_d  = ovf;
        if (rst) begin
            sum_d  = '0;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
    end

`ifdef FA_SELFCHECK_EN
    logic [WIDTH:0] ref_w;
    logic           err_d;

    assign ref_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        err_d = err_q;
        if (ref_w != {cout, sum}) begin
            err_d = 1'b1;
        end
        if (rst) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_fulladder_structural.sv
// Scoreboard bench for fulladder_structural at WIDTH=1 and WIDTH=8; FA_SELFCHECK_EN enables the err_q checks.

module tb_fulladder_structural;

    typedef struct packed {
        logic       ovf;
        logic       cout;
        logic [7:0] sum;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] a1, b1;
    logic       cin1;
    logic [7:0] a8, b8;
    logic       cin8;

    logic [0:0] sum1, sum1_q;
    logic       cout1, ovf1, cout1_q, ovf1_q;
    logic [7:0] sum8, sum8_q;
    logic       cout8, ovf8, cout8_q, ovf8_q;

    exp_t q1[$];
    exp_t q8[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] tab1 [8];

    always #5 clk = ~clk;

`ifdef FA_SELFCHECK_EN
    logic err1_q, err8_q;
`endif

    fulladder_structural #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .a      (a1),
        .b      (b1),
        .cin    (cin1),
        .sum    (sum1),
        .cout   (cout1),
        .ovf    (ovf1),
        .sum_q  (sum1_q),
        .cout_q (cout1_q),
        .ovf_q  (ovf1_q)
`ifdef FA_SELFCHECK_EN
        ,
        .err_q  (err1_q)
`endif
    );

    fulladder_structural #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .a      (a8),
        .b      (b8),
        .cin    (cin8),
        .sum    (sum8),
        .cout   (cout8),
        .ovf    (ovf8),
        .sum_q  (sum8_q),
        .cout_q (cout8_q),
        .ovf_q  (ovf8_q)
`ifdef FA_SELFCHECK_EN
        ,
        .err_q  (err8_q)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational result, push the
    // expected register contents, then pop and compare after the next posedge.
    task automatic step(input logic rst_v, input logic a1_v, input logic b1_v, input logic c1_v,
                        input logic [7:0] a8_v, input logic [7:0] b8_v, input logic c8_v);
        logic [1:0] e1;
        logic [8:0] e8;
        logic       eovf1, eovf8;
        exp_t       x1, x8, g1, g8;

        @(negedge clk);
        rst  = rst_v;
        a1   = a1_v;
        b1   = b1_v;
        cin1 = c1_v;
        a8   = a8_v;
        b8   = b8_v;
        cin8 = c8_v;
        #1;
        e1    = {1'b0, a1_v} + {1'b0, b1_v} + {1'b0, c1_v};
        eovf1 = c1_v ^ e1[1];
        e8    = {1'b0, a8_v} + {1'b0, b8_v} + {8'd0, c8_v};
        eovf8 = (a8_v[7] == b8_v[7]) && (e8[7] != a8_v[7]);
        check("w1_sum",  {31'd0, sum1},  {31'd0, e1[0]});
        check("w1_cout", {31'd0, cout1}, {31'd0, e1[1]});
        check("w1_ovf",  {31'd0, ovf1},  {31'd0, eovf1});
        check("w8_sum",  {24'd0, sum8},  {24'd0, e8[7:0]});
        check("w8_cout", {31'd0, cout8}, {31'd0, e8[8]});
        check("w8_ovf",  {31'd0, ovf8},  {31'd0, eovf8});

        x1 = rst_v ? exp_t'(0) : exp_t'{eovf1, e1[1], {7'd0, e1[0]}};
        x8 = rst_v ? exp_t'(0) : exp_t'{eovf8, e8[8], e8[7:0]};
        q1.push_back(x1);
        q8.push_back(x8);

        @(posedge clk);
        #1;
        if (q1.size() == 0 || q8.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            g1 = q1.pop_front();
            g8 = q8.pop_front();
            check("w1_sum_q",  {31'd0, sum1_q},  {31'd0, g1.sum[0]});
            check("w1_cout_q", {31'd0, cout1_q}, {31'd0, g1.cout});
            check("w1_ovf_q",  {31'd0, ovf1_q},  {31'd0, g1.ovf});
            check("w8_sum_q",  {24'd0, sum8_q},  {24'd0, g8.sum});
            check("w8_cout_q", {31'd0, cout8_q}, {31'd0, g8.cout});
            check("w8_ovf_q",  {31'd0, ovf8_q},  {31'd0, g8.ovf});
        end
    endtask

    initial begin
        // {cout,sum} for (a,b,cin) = 000..111
        tab1[0] = 2'b00; tab1[1] = 2'b01; tab1[2] = 2'b01; tab1[3] = 2'b10;
        tab1[4] = 2'b01; tab1[5] = 2'b10; tab1[6] = 2'b10; tab1[7] = 2'b11;

        rst = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step(1'b0, v[2], v[1], v[0], 8'h00, 8'h00, 1'b0);
            check("w1_table", {30'd0, cout1, sum1}, {30'd0, tab1[i]});
        end

        // Reset held two edges with all-ones inputs; combinational ports stay live.
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        check("rst_comb_sum",  {31'd0, sum1},  32'd1);
        check("rst_comb_cout", {31'd0, cout1}, 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        check("rel_sum_q",  {31'd0, sum1_q},  32'd1);
        check("rel_cout_q", {31'd0, cout1_q}, 32'd1);
        check("w8_allones", {23'd0, cout8, sum8}, 32'h1FF);

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("w8_zero", {22'd0, ovf8, cout8, sum8}, 32'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
        check("w8_ripple", {22'd0, ovf8, cout8, sum8}, 32'h100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b0);
        check("w8_posovf", {22'd0, ovf8, cout8, sum8}, 32'h280);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0);
        check("w8_negovf", {22'd0, ovf8, cout8, sum8}, 32'h300);

        // Mid-stream reset pulse followed by normal reload.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            logic [31:0] r;
            r = $urandom;
            step(1'b0, r[0], r[1], r[2], 8'($urandom), 8'($urandom), r[3]);
        end

`ifdef FA_SELFCHECK_EN
        check("err1_clean", {31'd0, err1_q}, 32'd0);
        check("err8_clean", {31'd0, err8_q}, 32'd0);
        @(negedge clk);
        a8 = 8'h08; b8 = 8'h00; cin8 = 1'b0;
        force dut8.sum_w[3] = 1'b0;
        @(posedge clk); #1;
        check("err8_set", {31'd0, err8_q}, 32'd1);
        @(negedge clk);
        release dut8.sum_w[3];
        @(posedge clk); #1;
        check("err8_hold", {31'd0, err8_q}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("err8_rst", {31'd0, err8_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fulladder_structural.md
Name: fulladder_structural

Overview:
- Gate-level (structural) adder built from 1-bit full-adder cells (XOR/AND/OR primitives only), chained ripple-carry over WIDTH bits.
- Default WIDTH=1 gives a single full adder: sum = a^b^cin, cout = majority(a,b,cin).
- Combinational result ports plus a registered copy, for use as a leaf arithmetic cell in datapaths and as a teaching and verification reference.

Parameters:
- WIDTH, 1, operand width in bits (>=1); number of chained full-adder cells.

Ports:
- clk  input  1  rising-edge clock; used only by the output registers.
- rst  input  1  synchronous active-high reset; clears the registered outputs.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  combinational sum bits.
- cout  output  1  combinational carry-out of MSB cell.
- ovf  output  1  combinational two's-complement overflow (carry into MSB XOR cout).
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered cout.
- ovf_q  output  1  registered ovf.

Behaviour:
- Cell i:
  - s_i = a[i]^b[i]^c_i
  - c_{i+1} = (a[i]&b[i]) | (c_i&(a[i]^b[i]))
  - c_0 = cin
- Cells are instantiated with generate. No behavioural "+" operator anywhere in the datapath.
- Arithmetic: {cout,sum} = a + b + cin, exact, WIDTH+1 bits; no truncation beyond WIDTH+1.
- ovf = c_{WIDTH-1} ^ c_WIDTH. For WIDTH=1, ovf = cin ^ cout.
- Combinational ports (sum, cout, ovf):
  - Zero-cycle latency; settle within the same delta as an input change.
  - Independent of clk and rst, so a reset does not force them.
- Registered ports:
  - Every rising clk edge: sum_q<=sum, cout_q<=cout, ovf_q<=ovf. One-cycle latency.
  - No enable; registers load every cycle.
  - rst=1 at a rising edge: sum_q, cout_q, ovf_q <= 0. Reset has priority over load.
  - Reset asserted mid-stream: the registers clear on the next edge. They reload normally on the first edge with rst=0.
- No X-propagation masking: an X or Z on any input may propagate to the outputs.
- Boundary cases:
  - All-ones + cin=1: sum = all-ones, cout = 1.
  - All-zeros, cin=0: sum = 0, cout = 0.

Optional Feature:
- Macro FA_SELFCHECK_EN.
- When defined:
  - Adds output port err_q (1 bit).
  - A behavioural model computes a+b+cin each cycle and compares it with {cout,sum}.
  - On any mismatch at a rising clk edge, err_q sets to 1 and stays set until rst.
  - err_q resets to 0.
- When undefined:
  - No err_q port.
  - No reference logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1 exhaustive sweep of (a,b,cin) over 000..111, holding each for 10 time units -> (sum,cout) = (0,0),(1,0),(1,0),(0,1),(1,0),(0,1),(0,1),(1,1); ovf = cin^cout.
- WIDTH=1, rst=1 for 2 edges with a=b=cin=1 -> sum=1, cout=1 combinationally; sum_q=cout_q=ovf_q=0. Release rst -> after next edge sum_q=1, cout_q=1.
- WIDTH=8, a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1, ovf=0 (full ripple).
- WIDTH=8, a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
- WIDTH=8, randomised 1000 vectors with a clock running -> {cout,sum}=a+b+cin each vector; sum_q/cout_q equal the previous cycle's combinational values.
- FA_SELFCHECK_EN defined, random run -> err_q stays 0. Forced fault on one cell via force -> err_q goes 1 next edge and holds until rst.
